// File: rtl/uart_pkg.sv
// uart_pkg -- shared defaults for the UART baud generator slice.
//   DVSR_W_DEF   : integer divisor width
//   FRAC_W_DEF   : fractional divisor width
//   OVS_DEF      : oversample ticks per bit (power of two, >= 4)
//   DEF_DVSR_DEF : reset value of the active integer divisor
//   os_cnt_w()   : width of a modulo-OVS counter
package uart_pkg;

  localparam int unsigned DVSR_W_DEF   = 16;
  localparam int unsigned FRAC_W_DEF   = 4;
  localparam int unsigned OVS_DEF      = 16;
  localparam int unsigned DEF_DVSR_DEF = 0;

  function automatic int unsigned os_cnt_w(input int unsigned ovs);
    return (ovs > 1) ? $clog2(ovs) : 1;
  endfunction

endpackage

// File: rtl/baud_os_div.sv
// baud_os_div -- divide-by-OVS stage turning oversample ticks into bit ticks.
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset
//   tick     : one-cycle strobe, an oversample period has just ended
//   realign  : re-phase strobe; preloads the counter to mid-bit
//   tick_bit : registered, high with the tick_os that completes OVS ticks
module baud_os_div
  import uart_pkg::*;
#(
  parameter int unsigned OVS = OVS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic realign,
  output logic tick_bit
);

  localparam int unsigned     OS_W    = os_cnt_w(OVS);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVS - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVS / 2);

  logic [OS_W-1:0] os_cnt;

  // Preloading OVS/2 puts the first bit tick after a realign in mid-bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      os_cnt   <= '0;
      tick_bit <= 1'b0;
    end else if (realign) begin
      os_cnt   <= OS_HALF;
      tick_bit <= 1'b0;
    end else if (tick) begin
      tick_bit <= (os_cnt == OS_LAST);
      os_cnt   <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
    end else begin
      tick_bit <= 1'b0;
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac -- fractional baud-rate generator with shadowed divisor.
//   clk         : rising-edge clock
//   reset       : synchronous active-high reset
//   en          : count enable; low freezes all counters and ticks
//   dvsr_int    : integer divisor request (period = dvsr_int + 1 cycles)
//   dvsr_frac   : fractional divisor request, in 1/2^FRAC_W cycles
//   cfg_load    : strobe capturing dvsr_int/dvsr_frac into the shadow
//   realign     : strobe restarting the period and re-phasing the bit tick
//   tick_os     : one-cycle oversample tick
//   tick_bit    : one-cycle bit tick, every OVS oversample ticks
//   cfg_pending : shadow holds a divisor not yet made active
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int unsigned DVSR_W   = DVSR_W_DEF,
  parameter int unsigned FRAC_W   = FRAC_W_DEF,
  parameter int unsigned OVS      = OVS_DEF,
  parameter int unsigned DEF_DVSR = DEF_DVSR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DVSR_W-1:0] dvsr_int,
  input  logic [FRAC_W-1:0] dvsr_frac,
  input  logic              cfg_load,
  input  logic              realign,
  output logic              tick_os,
  output logic              tick_bit,
  output logic              cfg_pending
);

  localparam int unsigned CNT_W = DVSR_W + 1;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cur_term;
  logic [FRAC_W-1:0] facc;
  logic [DVSR_W-1:0] act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [DVSR_W-1:0] sh_int;
  logic [FRAC_W-1:0] sh_frac;

  logic              term_hit;
  logic              xfer;
  logic [FRAC_W:0]   facc_sum;
  logic [CNT_W-1:0]  wrap_term;
  logic [CNT_W-1:0]  restart_term;

  // The running period's terminal count lives in cur_term, fixed when the
  // period starts. A divisor transfer therefore only changes act_int/act_frac
  // and never the length of the period already in progress, even when the
  // transfer happens while en is low.
  always_comb begin
    term_hit     = en && (cnt == cur_term);
    xfer         = cfg_pending && (realign || term_hit || !en);
    facc_sum     = {1'b0, facc} + {1'b0, act_frac};
    restart_term = xfer ? CNT_W'(sh_int) : CNT_W'(act_int);
    if (xfer) begin
      // Transfer clears facc, so the next period carries no extra cycle.
      wrap_term = CNT_W'(sh_int);
    end else begin
      wrap_term = CNT_W'(act_int) + CNT_W'(facc_sum[FRAC_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      cur_term    <= CNT_W'(DEF_DVSR);
      facc        <= '0;
      act_int     <= DVSR_W'(DEF_DVSR);
      act_frac    <= '0;
      sh_int      <= '0;
      sh_frac     <= '0;
      cfg_pending <= 1'b0;
      tick_os     <= 1'b0;
    end else begin
      if (xfer) begin
        act_int  <= sh_int;
        act_frac <= sh_frac;
      end

      // A load in the same cycle as a transfer re-arms the shadow.
      if (cfg_load) begin
        sh_int      <= dvsr_int;
        sh_frac     <= dvsr_frac;
        cfg_pending <= 1'b1;
      end else if (xfer) begin
        cfg_pending <= 1'b0;
      end

      if (realign) begin
        cnt      <= '0;
        facc     <= '0;
        cur_term <= restart_term;
        tick_os  <= 1'b0;
      end else if (term_hit) begin
        cnt      <= '0;
        cur_term <= wrap_term;
        facc     <= xfer ? '0 : facc_sum[FRAC_W-1:0];
        tick_os  <= 1'b1;
      end else begin
        tick_os <= 1'b0;
        if (en) begin
          cnt <= cnt + 1'b1;
        end
        if (xfer) begin
          facc <= '0;
        end
      end
    end
  end

  baud_os_div #(
    .OVS(OVS)
  ) u_os_div (
    .clk      (clk),
    .reset    (reset),
    .tick     (term_hit),
    .realign  (realign),
    .tick_bit (tick_bit)
  );

endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 SHALL have parameter: DVSR_W, 16, integer divisor width.
REQ-002 SHALL have parameter: FRAC_W, 4, fractional divisor width.
REQ-003 SHALL have parameter: OVS, 16, oversample ticks per bit (power of two, >=4).
REQ-004 SHALL have parameter: DEF_DVSR, 0, reset value of the active integer divisor.
REQ-005 SHALL have port: clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port: en  in  1  count enable; low = freeze.
REQ-008 SHALL have port: dvsr_int  in  DVSR_W  integer divisor request.
REQ-009 SHALL have port: dvsr_frac  in  FRAC_W  fractional divisor request.
REQ-010 SHALL have port: cfg_load  in  1  one-cycle strobe capturing dvsr_int/dvsr_frac into the shadow.
REQ-011 SHALL have port: realign  in  1  one-cycle strobe re-phasing the bit tick, e.g. RX start edge.
REQ-012 SHALL have port: tick_os  out  1  one-cycle oversample tick.
REQ-013 SHALL have port: tick_bit  out  1  one-cycle bit tick, every OVS tick_os.
REQ-014 SHALL have port: cfg_pending  out  1  shadow captured, not yet active.

Function
REQ-015 SHALL count cnt from 0 to term; term = act_int, or act_int+1 when the current period carries a fractional extra cycle.
REQ-016 SHALL add act_frac to a FRAC_W-bit accumulator facc at each terminal count; a carry-out extends the next period by exactly one cycle.
REQ-017 SHALL produce an average oversample period of act_int + 1 + act_frac/2^FRAC_W cycles.
REQ-018 SHALL assert tick_os for exactly one cycle, registered, in the cycle after cnt == term.
REQ-019 SHALL, with act_int = 0 and act_frac = 0 and en high, hold tick_os high every cycle.
REQ-020 SHALL count tick_os modulo OVS in os_cnt; tick_bit SHALL be asserted together with tick_os when os_cnt == OVS-1, and os_cnt SHALL then wrap to 0.
REQ-021 SHALL, while en is low, hold cnt, facc and os_cnt, and drive tick_os = tick_bit = 0.
REQ-022 SHALL latch the shadow on cfg_load and set cfg_pending.
REQ-023 SHALL transfer the shadow to act_int/act_frac, and clear cfg_pending, at the next terminal count, or on the next cycle if en is low.
REQ-024 SHALL leave the running period length unchanged by a transfer; the new divisor SHALL govern from the following period.
REQ-025 SHALL, on a transfer, clear facc.
REQ-026 SHALL, on a second cfg_load before transfer, overwrite the shadow (last write wins).
REQ-027 SHALL, on realign, clear cnt and facc, load os_cnt with OVS/2, and drive both ticks low in the next cycle.
REQ-028 SHALL deliver the first tick_bit after a realign after OVS/2 tick_os, i.e. mid-bit.
REQ-029 SHALL apply priority: reset > realign > config transfer > normal counting.
REQ-030 SHALL perform a pending transfer on realign, since realign restarts a period.
REQ-031 SHALL use unsigned arithmetic; the cnt width SHALL be DVSR_W+1, so term = 2^DVSR_W-1+1 cannot overflow.

Reset
REQ-032 SHALL, on reset, clear cnt, facc, os_cnt, tick_os, tick_bit, cfg_pending and the shadow.
REQ-033 SHALL, on reset, load act_int with DEF_DVSR and clear act_frac.
REQ-034 SHALL, on a reset asserted mid-period, discard all partial count and pending config, with no tick in the following cycle.

Structure
REQ-035 SHALL place DVSR_W, FRAC_W and OVS defaults in the shared package uart_pkg.
REQ-036 SHALL implement the ÷OVS stage (os_cnt, tick_bit, realign preload) as sub-module baud_os_div.

Verification
REQ-037 SHALL cover: dvsr_int=3, frac=0, en=1 -> tick_os every 4 cycles; tick_bit every 64 cycles (OVS=16).
REQ-038 SHALL cover: dvsr_int=3, frac=8 -> periods alternate 4,5; exactly 8 tick_os in 36 cycles.
REQ-039 SHALL cover: cfg_load dvsr_int=7 mid-period with dvsr_int=3 active -> current period ends at 4 cycles, next periods 8 cycles; cfg_pending high exactly in between.
REQ-040 SHALL cover: realign 10 cycles after a tick_bit with dvsr_int=3 -> no tick the next cycle; tick_bit after 8 tick_os (32 cycles).
REQ-041 SHALL cover: en low for 5 cycles mid-period -> no ticks; period resumes with remaining count, stretched by 5 cycles.
REQ-042 SHALL cover: reset during a pending config -> cfg_pending=0, act_int=DEF_DVSR, first tick_os after DEF_DVSR+1 cycles.
